// File: rtl/ddc_hop_pkg.sv
// Shared constants and FSM state type for the receive-DDC frequency-hop sequencer.
package ddc_hop_pkg;

    localparam int FCW_W   = 28;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int DWELL_W = 16;
    localparam int SETTLE  = 6;

    localparam int SETTLE_CNT_W = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DWELL  = 2'd3
    } state_t;

endpackage

// File: rtl/ddc_hop_tbl.sv
// Hop table: DEPTH x FCW_W register file, synchronous write, asynchronous read.
// A same-cycle write and read of one address returns the old word.
module ddc_hop_tbl
    import ddc_hop_pkg::*;
(
    input  logic              clk_200m,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [FCW_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [FCW_W-1:0]  rd_data
);

    // Contents are deliberately not reset; software loads the table before start.
    logic [FCW_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_200m) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ddc_hop_ctrl.sv
// Frequency-hop sequencer: LOAD -> SETTLE (blank while the new tone propagates) -> DWELL.
// Optional hop counter built when DDC_HOP_CNT_EN is defined; otherwise hop_count is 0.
module ddc_hop_ctrl
    import ddc_hop_pkg::*;
(
    input  logic               clk_200m,
    input  logic               cfg_rst,
    input  logic               tbl_wr_en,
    input  logic [ADDR_W-1:0]  tbl_wr_addr,
    input  logic [FCW_W-1:0]   tbl_wr_data,
    input  logic [ADDR_W:0]    hop_len,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic               start,
    input  logic               stop,
    output logic [FCW_W-1:0]   fcw_data,
    output logic               rx_dds_en,
    output logic               iq_valid,
    output logic               busy,
    output logic [ADDR_W-1:0]  hop_idx,
    output logic               hop_strobe,
    output logic [31:0]        hop_count
);

    state_t                  state, state_nxt;
    logic [ADDR_W-1:0]       idx;
    logic [ADDR_W:0]         eff_len, len_clamped;
    logic [DWELL_W-1:0]      eff_dwell, dwell_clamped, dwell_cnt;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic [FCW_W-1:0]        rd_data;
    logic                    settle_last, dwell_last, idx_last;
    logic                    enter_load, start_accept;

    ddc_hop_tbl u_tbl (
        .clk_200m (clk_200m),
        .wr_en    (tbl_wr_en),
        .wr_addr  (tbl_wr_addr),
        .wr_data  (tbl_wr_data),
        .rd_addr  (idx),
        .rd_data  (rd_data)
    );

    always_comb begin
        len_clamped = hop_len;
        if (hop_len == '0) begin
            len_clamped = (ADDR_W+1)'(1);
        end else if (hop_len > (ADDR_W+1)'(DEPTH)) begin
            len_clamped = (ADDR_W+1)'(DEPTH);
        end
    end

    assign dwell_clamped = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;

    assign settle_last = (settle_cnt == SETTLE_CNT_W'(SETTLE - 1));
    assign dwell_last  = (dwell_cnt == eff_dwell - DWELL_W'(1));
    // >= also wraps safely if idx somehow sits beyond the active length
    assign idx_last    = ({1'b0, idx} >= eff_len - (ADDR_W+1)'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start && !stop) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_last) state_nxt = ST_DWELL;
            ST_DWELL:  if (dwell_last) state_nxt = ST_LOAD;
            default:   state_nxt = ST_IDLE;
        endcase
        if (stop && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
        end
    end

    assign enter_load   = (state_nxt == ST_LOAD);
    assign start_accept = (state == ST_IDLE) && enter_load;

    always_ff @(posedge clk_200m or posedge cfg_rst) begin
        if (cfg_rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            eff_len    <= '0;
            eff_dwell  <= '0;
            dwell_cnt  <= '0;
            settle_cnt <= '0;
            fcw_data   <= '0;
        end else begin
            state <= state_nxt;
            if (enter_load) begin
                eff_len   <= len_clamped;
                eff_dwell <= dwell_clamped;
            end
            if (state == ST_LOAD) begin
                fcw_data <= rd_data;
            end
            settle_cnt <= ((state == ST_SETTLE) && (state_nxt == ST_SETTLE))
                          ? settle_cnt + SETTLE_CNT_W'(1) : '0;
            dwell_cnt  <= ((state == ST_DWELL) && (state_nxt == ST_DWELL))
                          ? dwell_cnt + DWELL_W'(1) : '0;
            if (state_nxt == ST_IDLE) begin
                idx <= '0;
            end else if ((state == ST_DWELL) && enter_load) begin
                idx <= idx_last ? '0 : idx + ADDR_W'(1);
            end
        end
    end

    assign hop_strobe = (state == ST_LOAD);
    assign rx_dds_en  = (state == ST_SETTLE) && (settle_cnt == '0);
    assign iq_valid   = (state == ST_DWELL);
    assign busy       = (state != ST_IDLE);
    assign hop_idx    = idx;

`ifdef DDC_HOP_CNT_EN
    logic [31:0] hop_cnt_q;

    // Starting from IDLE counts as the first hop of a fresh run.
    always_ff @(posedge clk_200m or posedge cfg_rst) begin
        if (cfg_rst) begin
            hop_cnt_q <= '0;
        end else if (start_accept) begin
            hop_cnt_q <= 32'd1;
        end else if (enter_load) begin
            hop_cnt_q <= hop_cnt_q + 32'd1;
        end
    end

    assign hop_count = hop_cnt_q;
`else
    assign hop_count = '0;
`endif

endmodule
